transpose_ctrl: RTL and testbench

TRANSPOSE_CTRL -- requirements
Module: transpose_ctrl

---
 rtl/transpose_ctrl.sv | 140 ++++++++++++++
 tb/tb_transpose_ctrl.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/transpose_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// transpose_ctrl : grain-based pitch transposer read/crossfade controller
// Rev 1.0
// ----------------------------------------------------------------------------
module transpose_ctrl #(
  parameter int W      = 16,
  parameter int WINDOW = 512,
  parameter int XFADE  = 64,
  parameter int FRAC   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          strobe,
  input  logic signed [15:0]            pitch,
  output logic                          mem_rd_req,
  output logic [$clog2(WINDOW):0]       mem_rd_addr,
  input  logic                          mem_rd_ack,
  input  logic signed [W-1:0]           mem_rd_data,
  output logic signed [W-1:0]           sample_out,
  output logic                          out_valid,
  output logic                          busy,
  output logic                          grain_wrap,
  output logic                          overrun
);

  localparam int DW = $clog2(WINDOW);
  localparam int XW = $clog2(XFADE);
  localparam int PW = DW + FRAC;
  localparam int AW = DW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD_A = 2'd1,
    RD_B = 2'd2,
    MIX  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [PW-1:0]        phase;
  logic signed [15:0]   pitch_active;
  logic                 load_pending;
  logic signed [W-1:0]  tap_a, tap_b;
  logic [XW-1:0]        env_a, env_b;

  logic                 accept, drop;
  logic signed [15:0]   step;
  logic [PW:0]          sum_ext;
  logic [DW-1:0]        d, d_next;
  logic [XW-1:0]        env_a_next, env_b_next;
  logic signed [31:0]   prod_a, prod_b;

  assign accept = (state == IDLE) && strobe;
  assign drop   = (state != IDLE) && strobe;
  assign busy   = (state != IDLE);

  // Sign-extended step added one bit wider so bit PW flags carry or borrow.
  assign step    = load_pending ? pitch : pitch_active;
  assign sum_ext = {1'b0, phase} + {{(PW + 1 - 16){step[15]}}, step};
  assign d_next  = sum_ext[PW-1:FRAC];
  assign d       = phase[PW-1:FRAC];

  always_comb begin
    env_a_next = XW'(XFADE - 1);
    env_b_next = '0;
    if ({1'b0, d_next} < AW'(XFADE)) begin
      env_a_next = d_next[XW-1:0];
      env_b_next = XW'(XFADE - 1) - d_next[XW-1:0];
    end
  end

  assign prod_a = 32'(tap_a) * $signed(32'(env_a));
  assign prod_b = 32'(tap_b) * $signed(32'(env_b));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_rd_req  = 1'b0;
    mem_rd_addr = '0;
    case (state)
      IDLE: if (strobe) state_next = RD_A;
      RD_A: begin
        mem_rd_req  = 1'b1;
        mem_rd_addr = {1'b0, d};
        if (mem_rd_ack) state_next = RD_B;
      end
      RD_B: begin
        // Second tap sits exactly one window further back.
        mem_rd_req  = 1'b1;
        mem_rd_addr = {1'b1, d};
        if (mem_rd_ack) state_next = MIX;
      end
      MIX:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= '0;
      pitch_active <= '0;
      load_pending <= 1'b1;
      tap_a        <= '0;
      tap_b        <= '0;
      env_a        <= '0;
      env_b        <= '0;
      sample_out   <= '0;
      out_valid    <= 1'b0;
      grain_wrap   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      grain_wrap <= 1'b0;
      if (drop) overrun <= 1'b1;
      if (accept) begin
        phase      <= sum_ext[PW-1:0];
        env_a      <= env_a_next;
        env_b      <= env_b_next;
        grain_wrap <= sum_ext[PW];
        // A new pitch only takes effect at a grain boundary.
        if (load_pending || sum_ext[PW]) begin
          pitch_active <= pitch;
          load_pending <= 1'b0;
        end
      end
      if (state == RD_A && mem_rd_ack) tap_a <= mem_rd_data;
      if (state == RD_B && mem_rd_ack) tap_b <= mem_rd_data;
      if (state == MIX) begin
        sample_out <= W'((prod_a >>> XW) + (prod_b >>> XW));
        out_valid  <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_transpose_ctrl.sv
`default_nettype none
// Testbench for transpose_ctrl: randomized grains checked against a
// phase/envelope reference model kept in plain integer arithmetic.
module tb_transpose_ctrl;

  localparam int W      = 16;
  localparam int WINDOW = 512;
  localparam int XFADE  = 64;
  localparam int FRAC   = 8;
  localparam int PH_MOD = WINDOW << FRAC;

  logic               clk = 1'b0;
  logic               rst, strobe, mem_rd_ack;
  logic signed [15:0] pitch;
  logic               mem_rd_req;
  logic [9:0]         mem_rd_addr;
  logic signed [15:0] mem_rd_data, sample_out;
  logic               out_valid, busy, grain_wrap, overrun;

  int n_checks = 0, n_fail = 0;
  int cyc, extra_at;
  int phase_m, pitch_active_m;
  bit load_pending_m, exp_overrun;
  logic signed [15:0] mem [0:2*WINDOW-1];

  transpose_ctrl #(.W(W), .WINDOW(WINDOW), .XFADE(XFADE), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .strobe(strobe), .pitch(pitch),
    .mem_rd_req(mem_rd_req), .mem_rd_addr(mem_rd_addr),
    .mem_rd_ack(mem_rd_ack), .mem_rd_data(mem_rd_data),
    .sample_out(sample_out), .out_valid(out_valid), .busy(busy),
    .grain_wrap(grain_wrap), .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic int fdiv(int x);
    if (x >= 0) return x / XFADE;
    return -((-x + XFADE - 1) / XFADE);
  endfunction

  function automatic int wrap16(int x);
    logic signed [15:0] t;
    t = x[15:0];
    return int'(t);
  endfunction

  task automatic reset_model;
    phase_m = 0; pitch_active_m = 0; load_pending_m = 1; exp_overrun = 0;
  endtask

  task automatic reset_dut;
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    reset_model();
  endtask

  task automatic step_cycle;
    @(negedge clk);
    cyc++;
    strobe = (cyc == extra_at);
  endtask

  // One full grain sample: strobe, two reads with da/db wait cycles, mix.
  // xat > 0 injects an extra strobe in that cycle (it must be dropped).
  task automatic run_sample(input int da, input int db, input int xat);
    int stp, raw, d, ea, eb, ta, tb, exp_out;
    bit wr;
    stp = load_pending_m ? int'(pitch) : pitch_active_m;
    raw = phase_m + stp;
    wr  = (raw < 0) || (raw >= PH_MOD);
    phase_m = ((raw % PH_MOD) + PH_MOD) % PH_MOD;
    if (load_pending_m || wr) begin
      pitch_active_m = int'(pitch); load_pending_m = 0;
    end
    d = phase_m / (1 << FRAC);
    if (d < XFADE) begin ea = d; eb = XFADE - 1 - d; end
    else begin ea = XFADE - 1; eb = 0; end
    ta = int'(mem[d]); tb = int'(mem[d + WINDOW]);
    exp_out = wrap16(fdiv(ta * ea) + fdiv(tb * eb));
    if (xat > 0) exp_overrun = 1;

    extra_at = xat; cyc = 0; strobe = 1;
    step_cycle();
    n_checks++;
    if (grain_wrap !== wr) begin
      n_fail++; $display("FAIL grain_wrap: got %b expected %b", grain_wrap, wr);
    end
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++; $display("FAIL busy_reading: got %b expected 1", busy);
    end
    for (int k = 0; k <= da; k++) begin
      n_checks++;
      if (mem_rd_req !== 1'b1 || mem_rd_addr !== 10'(d)) begin
        n_fail++; $display("FAIL rd_a: req %b addr %0d expected req 1 addr %0d", mem_rd_req, mem_rd_addr, d);
      end
      mem_rd_ack  = (k == da);
      mem_rd_data = (k == da) ? mem[d] : 16'($urandom);
      step_cycle();
    end
    for (int k = 0; k <= db; k++) begin
      n_checks++;
      if (mem_rd_req !== 1'b1 || mem_rd_addr !== 10'(d + WINDOW)) begin
        n_fail++; $display("FAIL rd_b: req %b addr %0d expected req 1 addr %0d", mem_rd_req, mem_rd_addr, d + WINDOW);
      end
      mem_rd_ack  = (k == db);
      mem_rd_data = (k == db) ? mem[d + WINDOW] : 16'($urandom);
      step_cycle();
    end
    n_checks++;
    if (mem_rd_req !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mix_cycle: req %b out_valid %b expected 0 0", mem_rd_req, out_valid);
    end
    mem_rd_ack = 1'($urandom);
    mem_rd_data = 16'($urandom);
    step_cycle();
    mem_rd_ack = 0;
    n_checks++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL out_valid_latency: got %b expected 1 at cycle %0d", out_valid, cyc);
    end
    n_checks++;
    if (sample_out !== 16'(exp_out)) begin
      n_fail++; $display("FAIL sample_out: got %0d expected %0d", sample_out, exp_out);
    end
    n_checks++;
    if (busy !== 1'b0 || overrun !== exp_overrun) begin
      n_fail++; $display("FAIL idle_flags: busy %b overrun %b expected 0 %b", busy, overrun, exp_overrun);
    end
    step_cycle();
    n_checks++;
    if (out_valid !== 1'b0) begin
      n_fail++; $display("FAIL out_valid_pulse: got %b expected 0", out_valid);
    end
  endtask

  task automatic test_reset;
    @(negedge clk); rst = 1; strobe = 1; mem_rd_ack = 1; pitch = 16'h1234;
    @(negedge clk); rst = 0; strobe = 0; mem_rd_ack = 0;
    n_checks++;
    if ({busy, mem_rd_req, out_valid, grain_wrap, overrun} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000", {busy, mem_rd_req, out_valid, grain_wrap, overrun});
    end
    n_checks++;
    if (mem_rd_addr !== 10'd0 || sample_out !== 16'sd0) begin
      n_fail++; $display("FAIL reset_data: addr %0d sample %0d expected 0 0", mem_rd_addr, sample_out);
    end
    reset_model();
  endtask

  task automatic test_zero_pitch;
    reset_dut();
    pitch = 0; mem[512] = 16'sd1000;
    run_sample(0, 0, 0);
    n_checks++;
    if (sample_out !== 16'sd984) begin
      n_fail++; $display("FAIL zero_pitch_hold: got %0d expected 984", sample_out);
    end
  endtask

  task automatic test_negative_wrap;
    reset_dut();
    pitch = -16'sh0100; mem[511] = -16'sd2000;
    run_sample(0, 0, 0);
    n_checks++;
    if (sample_out !== -16'sd1969) begin
      n_fail++; $display("FAIL negative_wrap: got %0d expected -1969", sample_out);
    end
  endtask

  task automatic test_ack_delay;
    for (int i = 0; i < 3; i++) begin
      pitch = 16'($urandom);
      run_sample(3, 3, 0);
    end
  endtask

  task automatic test_overrun;
    pitch = 16'sh0345;
    run_sample(1, 1, 2);
    run_sample(0, 0, 0);
    run_sample(0, 0, 3);
  endtask

  task automatic test_pitch_latch;
    reset_dut();
    pitch = -16'sh0100;
    run_sample(0, 0, 0);
    pitch = -16'sh0080;
    for (int i = 0; i < 514; i++) run_sample(0, 0, 0);
  endtask

  task automatic test_reset_mid_read;
    int seen;
    pitch = 16'($urandom);
    @(negedge clk); strobe = 1;
    @(negedge clk); strobe = 0; mem_rd_ack = 1; mem_rd_data = 16'($urandom);
    @(negedge clk); mem_rd_ack = 0;
    @(negedge clk);
    n_checks++;
    if (mem_rd_req !== 1'b1) begin
      n_fail++; $display("FAIL rd_b_wait: req %b expected 1", mem_rd_req);
    end
    rst = 1;
    @(negedge clk); rst = 0;
    n_checks++;
    if (mem_rd_req !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_fail++; $display("FAIL abort_read: req %b busy %b overrun %b expected 0 0 0", mem_rd_req, busy, overrun);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_no_valid: got %0d pulses expected 0", seen);
    end
    reset_model();
  endtask

  task automatic test_random;
    int da, db, xat, gap;
    for (int i = 0; i < 60; i++) begin
      pitch = 16'($urandom);
      da = $urandom_range(0, 3);
      db = $urandom_range(0, 3);
      xat = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3 + da + db) : 0;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        mem_rd_ack = 1'($urandom);
        @(negedge clk);
      end
      mem_rd_ack = 0;
      run_sample(da, db, xat);
    end
  endtask

  initial begin
    #5000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 0; strobe = 0; mem_rd_ack = 0; mem_rd_data = 0; pitch = 0;
    extra_at = 0; cyc = 0;
    for (int i = 0; i < 2 * WINDOW; i++) mem[i] = 16'($urandom);
    reset_model();
    test_reset();
    test_zero_pitch();
    test_negative_wrap();
    test_ack_delay();
    test_overrun();
    test_pitch_latch();
    test_reset_mid_read();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
